// File: rtl/sigma_delta_feeder.sv
// sigma_delta_feeder: buffers stereo PCM in a small FIFO and releases one pair every CLK_DIV clocks to two sigma-delta DACs.
// Optional macro SOFT_MUTE_EN replaces the hard mute with a per-tick attenuation ramp.
module sigma_delta_feeder #(
  parameter int MSBI    = 15,
  parameter int CLK_DIV = 512,
  parameter int FIFO_AW = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             enable,
  input  logic             mute,
  input  logic [MSBI:0]    in_l,
  input  logic [MSBI:0]    in_r,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [MSBI:0]    dac_l,
  output logic [MSBI:0]    dac_r,
  output logic             sample_tick,
  output logic             underrun,
  output logic [FIFO_AW:0] fifo_level
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0]   LEVEL_FULL   = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LEVEL_PRIMED = (FIFO_AW+1)'(DEPTH / 2);
  localparam logic [MSBI:0]      MIDSCALE     = {1'b1, {MSBI{1'b0}}};

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t             state;
  logic [DIV_W-1:0]   divider;
  logic [FIFO_AW-1:0] wrPtr;
  logic [FIFO_AW-1:0] rdPtr;
  logic [FIFO_AW:0]   levelNext;
  logic [MSBI:0]      memL [DEPTH];
  logic [MSBI:0]      memR [DEPTH];
  logic               tick;
  logic               push;
  logic               pop;
  logic [MSBI:0]      nextL;
  logic [MSBI:0]      nextR;

  assign tick = (state != IDLE) && (divider == DIV_LAST);
  assign push = enable && in_valid && in_ready;
  assign pop  = enable && (state == RUN) && tick && (fifo_level != '0);

  always_comb begin
    levelNext = fifo_level;
    if (push && !pop)
      levelNext = fifo_level + 1'b1;
    else if (pop && !push)
      levelNext = fifo_level - 1'b1;
  end

  // Storage carries no reset; pointers define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) begin
      memL[wrPtr] <= in_l;
      memR[wrPtr] <= in_r;
    end
  end

`ifdef SOFT_MUTE_EN
  localparam int ATT_W = $clog2(MSBI + 2);
  localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MSBI + 1);

  logic [ATT_W-1:0]   atten;
  logic [ATT_W-1:0]   attenNext;
  logic signed [MSBI:0] shiftL;
  logic signed [MSBI:0] shiftR;

  always_comb begin
    attenNext = atten;
    if (enable && tick) begin
      if (mute && atten != ATT_MAX)
        attenNext = atten + 1'b1;
      else if (!mute && atten != '0)
        attenNext = atten - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      atten <= '0;
    else
      atten <= attenNext;
  end

  // A full shift of a negative sample leaves -1, so the last step is forced to midscale.
  always_comb begin
    shiftL = $signed(memL[rdPtr]) >>> attenNext;
    shiftR = $signed(memR[rdPtr]) >>> attenNext;
    nextL  = (attenNext == ATT_MAX) ? MIDSCALE : ($unsigned(shiftL) ^ MIDSCALE);
    nextR  = (attenNext == ATT_MAX) ? MIDSCALE : ($unsigned(shiftR) ^ MIDSCALE);
  end
`else
  always_comb begin
    nextL = mute ? MIDSCALE : (memL[rdPtr] ^ MIDSCALE);
    nextR = mute ? MIDSCALE : (memR[rdPtr] ^ MIDSCALE);
  end
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      divider     <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      fifo_level  <= '0;
      in_ready    <= 1'b1;
      dac_l       <= MIDSCALE;
      dac_r       <= MIDSCALE;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else if (!enable) begin
      state       <= IDLE;
      divider     <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      fifo_level  <= '0;
      in_ready    <= 1'b1;
      dac_l       <= MIDSCALE;
      dac_r       <= MIDSCALE;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      divider     <= (state == IDLE || divider == DIV_LAST) ? '0 : divider + 1'b1;
      fifo_level  <= levelNext;
      in_ready    <= (levelNext != LEVEL_FULL);
      sample_tick <= pop;
      underrun    <= tick && (state == RUN) && (fifo_level == '0);
      if (push)
        wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
        dac_l <= nextL;
        dac_r <= nextR;
      end
      case (state)
        IDLE:    state <= PRIME;
        PRIME:   if (tick && fifo_level >= LEVEL_PRIMED) state <= RUN;
        RUN:     if (tick && fifo_level == '0) state <= PRIME;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
